// File: rtl/fro_sampler.sv
// Free-running-oscillator entropy harvester: synchronizes a ring-oscillator output,
// samples it at a fixed divider rate, von Neumann debiases pairs and packs words.
module fro_sampler #(
    parameter int WORD_W       = 8,
    parameter int SAMPLE_DIV   = 4,
    parameter int WARMUP_CYC   = 16,
    parameter int REPEAT_LIMIT = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              ro_in,
    output logic              fro_en,
    output logic              fro_rst,
    output logic [WORD_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              alarm
);
    localparam int WARM_W = $clog2(WARMUP_CYC + 1);
    localparam int DIV_W  = $clog2(SAMPLE_DIV + 1);
    localparam int BIT_W  = $clog2(WORD_W + 1);
    localparam int REP_W  = $clog2(REPEAT_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, WARM, RUN, HOLD} state_t;

    state_t              state;
    logic                ro_q1, ro_s;
    logic [WARM_W-1:0]   warm_cnt;
    logic [DIV_W-1:0]    div_cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [REP_W-1:0]    rep_cnt, rep_next;
    logic [WORD_W-1:0]   shreg, word_next;
    logic                pair_phase, first_bit, last_sample;
    logic                strobe, emit, word_done, trip;

    // ro_in is asynchronous to clk; only the second flop output is ever used.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ro_q1 <= 1'b0;
            ro_s  <= 1'b0;
        end else begin
            ro_q1 <= ro_in;
            ro_s  <= ro_q1;
        end
    end

    always_comb begin
        strobe    = (state == RUN) && (div_cnt == DIV_W'(SAMPLE_DIV - 1));
        rep_next  = REP_W'(1);
        if (rep_cnt != '0 && ro_s == last_sample)
            rep_next = rep_cnt + REP_W'(1);
        trip      = strobe && (rep_next == REP_W'(REPEAT_LIMIT));
        // Pair "first,second" emits the first bit when the two differ (10->1, 01->0).
        emit      = strobe && pair_phase && (first_bit != ro_s);
        word_next = {shreg[WORD_W-2:0], first_bit};
        word_done = emit && (bit_cnt == BIT_W'(WORD_W - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            fro_en      <= 1'b0;
            fro_rst     <= 1'b1;
            data_out    <= '0;
            data_valid  <= 1'b0;
            alarm       <= 1'b0;
            warm_cnt    <= '0;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            rep_cnt     <= '0;
            shreg       <= '0;
            pair_phase  <= 1'b0;
            first_bit   <= 1'b0;
            last_sample <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en && !alarm) begin
                        state    <= WARM;
                        warm_cnt <= '0;
                        fro_en   <= 1'b1;
                        fro_rst  <= 1'b0;
                    end
                end
                WARM: begin
                    if (warm_cnt == WARM_W'(WARMUP_CYC - 1)) begin
                        state   <= RUN;
                        div_cnt <= '0;
                    end else begin
                        warm_cnt <= warm_cnt + WARM_W'(1);
                    end
                end
                RUN: begin
                    if (strobe) begin
                        div_cnt     <= '0;
                        last_sample <= ro_s;
                        rep_cnt     <= rep_next;
                        pair_phase  <= ~pair_phase;
                        if (!pair_phase)
                            first_bit <= ro_s;
                        if (emit) begin
                            shreg   <= word_next;
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                        if (word_done) begin
                            data_out   <= word_next;
                            data_valid <= 1'b1;
                            state      <= HOLD;
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                HOLD: begin
                    if (data_valid && data_ready) begin
                        data_valid <= 1'b0;
                        bit_cnt    <= '0;
                        pair_phase <= 1'b0;
                        div_cnt    <= '0;
                        shreg      <= '0;
                        state      <= RUN;
                    end
                end
                default: state <= IDLE;
            endcase

            // NOTE: this block comes after the case on purpose; the last non-blocking
            // assignment wins, so abort and alarm override a word completing this cycle.
            if (state != IDLE && (!en || trip)) begin
                state      <= IDLE;
                fro_en     <= 1'b0;
                fro_rst    <= 1'b1;
                data_valid <= 1'b0;
                data_out   <= '0;
                div_cnt    <= '0;
                bit_cnt    <= '0;
                rep_cnt    <= '0;
                shreg      <= '0;
                pair_phase <= 1'b0;
            end
            if (trip)
                alarm <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fro_sampler.sv
// Self-checking bench for fro_sampler: drives one chosen raw bit per strobe window and
// predicts words from the sampled bit list with a pairwise debiasing model.
module tb_fro_sampler;
    localparam int WORD_W       = 8;
    localparam int SAMPLE_DIV   = 4;
    localparam int WARMUP_CYC   = 16;
    localparam int REPEAT_LIMIT = 32;

    logic              clk = 1'b0;
    logic              rst_n, en, ro_in, data_ready;
    logic              fro_en, fro_rst, data_valid, alarm;
    logic [WORD_W-1:0] data_out;

    int n_checks = 0;
    int n_pass   = 0;
    bit stim_q[$];

    fro_sampler #(
        .WORD_W(WORD_W), .SAMPLE_DIV(SAMPLE_DIV),
        .WARMUP_CYC(WARMUP_CYC), .REPEAT_LIMIT(REPEAT_LIMIT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .ro_in(ro_in),
        .fro_en(fro_en), .fro_rst(fro_rst), .data_out(data_out),
        .data_valid(data_valid), .data_ready(data_ready), .alarm(alarm)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Queue n pairs given MSB-first as raw samples (first of each pair first).
    task automatic push_pairs(input logic [31:0] pairs, input int n);
        logic [31:0] p;
        p = pairs;
        for (int i = 0; i < n; i++) begin
            stim_q.push_back(p[2*n-1-2*i]);
            stim_q.push_back(p[2*n-2-2*i]);
        end
    endtask

    // Request a run and wait until the block has just entered RUN.
    task automatic start_run();
        en = 1'b1;
        step(1);
        n_checks++;
        if (fro_rst !== 1'b0 || fro_en !== 1'b1)
            $display("FAIL start_warm: fro_en=%b fro_rst=%b, want 1 0", fro_en, fro_rst);
        else n_pass++;
        step(WARMUP_CYC);
    endtask

    // One strobe window per raw sample. A raw bit reaches the sampled point two edges
    // after it is driven, so the chosen bit is held only for the edge two before the
    // strobe and the other cycles carry noise.
    task automatic feed(input int max_strobes, input bit rand_ready,
                        output bit done, output logic [WORD_W-1:0] exp_word);
        bit samples[$];
        int n_emit = 0;
        bit early = 1'b0;
        bit b;
        done = 1'b0;
        exp_word = '0;
        for (int s = 0; s < max_strobes && !done; s++) begin
            b = (stim_q.size() > 0) ? stim_q.pop_front() : 1'($urandom);
            for (int c = 1; c <= SAMPLE_DIV; c++) begin
                ro_in = (c == SAMPLE_DIV - 2) ? b : 1'($urandom);
                data_ready = rand_ready ? 1'($urandom) : 1'b0;
                step(1);
                data_ready = 1'b0;
                if (c < SAMPLE_DIV && data_valid !== 1'b0) early = 1'b1;
            end
            samples.push_back(b);
            if (samples.size() % 2 == 0 && samples[samples.size()-2] != b) begin
                exp_word[WORD_W-1-n_emit] = samples[samples.size()-2];
                n_emit++;
            end
            if (n_emit == WORD_W) done = 1'b1;
            else if (data_valid !== 1'b0) early = 1'b1;
        end
        n_checks++;
        if (early) $display("FAIL feed_no_early_valid: data_valid=1 before the last strobe of the word, want 0");
        else n_pass++;
        if (done) begin
            n_checks++;
            if (data_valid !== 1'b1 || data_out !== exp_word)
                $display("FAIL feed_word: data_valid=%b data_out=%b, want 1 %b", data_valid, data_out, exp_word);
            else n_pass++;
        end
    endtask

    task automatic hold_accept(input int n_hold, input logic [WORD_W-1:0] exp_word);
        bit moved = 1'b0;
        for (int i = 0; i < n_hold; i++) begin
            ro_in = 1'($urandom);
            step(1);
            if (data_valid !== 1'b1 || data_out !== exp_word || fro_en !== 1'b1) moved = 1'b1;
        end
        n_checks++;
        if (moved) $display("FAIL hold_stable: data_valid=%b data_out=%b fro_en=%b, want 1 %b 1",
                            data_valid, data_out, fro_en, exp_word);
        else n_pass++;
        data_ready = 1'b1;
        step(1);
        data_ready = 1'b0;
        n_checks++;
        if (data_valid !== 1'b0) $display("FAIL accept_drop: data_valid=%b, want 0", data_valid);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; ro_in = 1'b0; data_ready = 1'b0;
        step(2);
        n_checks++;
        if (fro_en !== 1'b0 || fro_rst !== 1'b1 || data_out !== '0 || data_valid !== 1'b0 || alarm !== 1'b0)
            $display("FAIL reset_outputs: fro_en=%b fro_rst=%b data_out=%h valid=%b alarm=%b, want 0 1 00 0 0",
                     fro_en, fro_rst, data_out, data_valid, alarm);
        else n_pass++;
        en = 1'b1;
        step(1);
        n_checks++;
        if (fro_rst !== 1'b1 || fro_en !== 1'b0)
            $display("FAIL reset_holds_idle: fro_en=%b fro_rst=%b, want 0 1", fro_en, fro_rst);
        else n_pass++;
        #3 rst_n = 1'b1;
        step(1);
        n_checks++;
        if (fro_rst !== 1'b0 || fro_en !== 1'b1)
            $display("FAIL reset_release_first_edge: fro_en=%b fro_rst=%b, want 1 0", fro_en, fro_rst);
        else n_pass++;
        en = 1'b0;
        step(1);
        n_checks++;
        if (fro_en !== 1'b0 || fro_rst !== 1'b1)
            $display("FAIL warm_abort: fro_en=%b fro_rst=%b, want 0 1", fro_en, fro_rst);
        else n_pass++;
        step(1);
    endtask

    task automatic test_basic_word();
        bit done;
        logic [WORD_W-1:0] w;
        start_run();
        push_pairs(32'b10_01_10_10_01_01_10_01, 8);
        feed(16, 1'b0, done, w);
        n_checks++;
        if (done !== 1'b1 || data_out !== 8'b10110010)
            $display("FAIL basic_word: done=%b data_out=%b, want 1 10110010", done, data_out);
        else n_pass++;
        hold_accept(3, 8'b10110010);
    endtask

    task automatic test_skip_pairs();
        bit done;
        logic [WORD_W-1:0] w;
        push_pairs(32'b10_00_01_11_10_00_10_11_01_00_01_11_10_00_01_11, 16);
        feed(32, 1'b0, done, w);
        n_checks++;
        if (done !== 1'b1 || data_out !== 8'b10110010)
            $display("FAIL skip_pairs_word: done=%b data_out=%b, want 1 10110010", done, data_out);
        else n_pass++;
        hold_accept(50, 8'b10110010);
    endtask

    task automatic test_back_to_back();
        bit done;
        logic [WORD_W-1:0] w;
        for (int k = 0; k < 6; k++) begin
            feed(200, 1'b1, done, w);
            n_checks++;
            if (done !== 1'b1) $display("FAIL random_word_%0d: no word within 200 strobes", k);
            else n_pass++;
            hold_accept($urandom_range(0, 4), w);
        end
    endtask

    task automatic test_en_drop();
        bit done;
        logic [WORD_W-1:0] w;
        push_pairs(32'b10_01_10_10_01, 5);
        stim_q.push_back(1'b1);
        feed(11, 1'b0, done, w);
        n_checks++;
        if (done !== 1'b0) $display("FAIL partial_not_done: done=%b, want 0", done);
        else n_pass++;
        en = 1'b0;
        step(1);
        n_checks++;
        if (fro_en !== 1'b0 || fro_rst !== 1'b1 || data_valid !== 1'b0)
            $display("FAIL en_drop_idle: fro_en=%b fro_rst=%b valid=%b, want 0 1 0", fro_en, fro_rst, data_valid);
        else n_pass++;
        step(3);
        start_run();
        push_pairs(32'b01_10_01_01_10_10_01_10, 8);
        feed(16, 1'b0, done, w);
        n_checks++;
        if (done !== 1'b1 || data_out !== 8'b01001101)
            $display("FAIL post_reassert_word: done=%b data_out=%b, want 1 01001101", done, data_out);
        else n_pass++;
        hold_accept(2, 8'b01001101);
    endtask

    task automatic test_async_reset_hold();
        bit done;
        logic [WORD_W-1:0] w;
        feed(200, 1'b0, done, w);
        n_checks++;
        if (done !== 1'b1) $display("FAIL pre_reset_word: no word within 200 strobes");
        else n_pass++;
        step(2);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (data_valid !== 1'b0 || fro_rst !== 1'b1 || fro_en !== 1'b0 || data_out !== '0)
            $display("FAIL async_reset: valid=%b fro_rst=%b fro_en=%b data_out=%h, want 0 1 0 00",
                     data_valid, fro_rst, fro_en, data_out);
        else n_pass++;
        en = 1'b0;
        #1 rst_n = 1'b1;
        step(1);
        n_checks++;
        if (fro_rst !== 1'b1 || data_valid !== 1'b0)
            $display("FAIL after_reset_idle: fro_rst=%b valid=%b, want 1 0", fro_rst, data_valid);
        else n_pass++;
    endtask

    task automatic test_stuck_alarm();
        bit stuck_ok = 1'b1;
        ro_in = 1'b1;
        start_run();
        step(SAMPLE_DIV * (REPEAT_LIMIT - 1) + SAMPLE_DIV - 1);
        n_checks++;
        if (alarm !== 1'b0) $display("FAIL alarm_early: alarm=%b before the 32nd strobe, want 0", alarm);
        else n_pass++;
        step(1);
        n_checks++;
        if (alarm !== 1'b1 || fro_en !== 1'b0 || fro_rst !== 1'b1 || data_valid !== 1'b0)
            $display("FAIL alarm_trip: alarm=%b fro_en=%b fro_rst=%b valid=%b, want 1 0 1 0",
                     alarm, fro_en, fro_rst, data_valid);
        else n_pass++;
        for (int i = 0; i < 12; i++) begin
            en = 1'(i % 2);
            step(1);
            if (alarm !== 1'b1 || fro_en !== 1'b0) stuck_ok = 1'b0;
        end
        n_checks++;
        if (!stuck_ok) $display("FAIL alarm_sticky: alarm=%b fro_en=%b, want 1 0", alarm, fro_en);
        else n_pass++;
        en = 1'b1;
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        step(1);
        n_checks++;
        if (alarm !== 1'b0 || fro_rst !== 1'b0 || fro_en !== 1'b1)
            $display("FAIL alarm_cleared_restart: alarm=%b fro_rst=%b fro_en=%b, want 0 0 1", alarm, fro_rst, fro_en);
        else n_pass++;
        en = 1'b0;
        step(2);
    endtask

    initial begin
        test_reset();
        test_basic_word();
        test_skip_pairs();
        test_back_to_back();
        test_en_drop();
        test_async_reset_hold();
        test_stuck_alarm();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fro_sampler.md
FRO_SAMPLER -- requirements
Module: fro_sampler

Interface
REQ-001 SHALL provide parameter WORD_W, default 8, the output word width in bits (>=2).
REQ-002 SHALL provide parameter SAMPLE_DIV, default 4, the number of clk cycles between raw samples (>=1).
REQ-003 SHALL provide parameter WARMUP_CYC, default 16, the number of oscillator settle cycles after enable (>=1).
REQ-004 SHALL provide parameter REPEAT_LIMIT, default 32, the number of consecutive identical raw samples that trips the alarm (>=2).
REQ-005 SHALL have port clk, input, 1 bit: the single system clock; all state is in this domain.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port en, input, 1 bit: run request from the controller.
REQ-008 SHALL have port ro_in, input, 1 bit: raw ring-oscillator output, asynchronous to clk.
REQ-009 SHALL have port fro_en, output, 1 bit: drives the oscillator enable.
REQ-010 SHALL have port fro_rst, output, 1 bit: drives the oscillator reset (active-high).
REQ-011 SHALL have port data_out, output, WORD_W bits: the harvested random word.
REQ-012 SHALL have port data_valid, output, 1 bit: data_out holds a complete word.
REQ-013 SHALL have port data_ready, input, 1 bit: the consumer accepts the word.
REQ-014 SHALL have port alarm, output, 1 bit: sticky health failure flag.

Function
REQ-015 SHALL pass ro_in through a two-flop synchronizer; ro_s is the second flop's output, and only ro_s is sampled.
REQ-016 SHALL implement FSM states IDLE, WARM, RUN and HOLD.
REQ-017 IDLE SHALL drive fro_en=0 and fro_rst=1, and on en=1 with alarm=0 SHALL move to WARM the next cycle with the warm counter cleared.
REQ-018 WARM SHALL drive fro_en=1 and fro_rst=0, take no samples, and move to RUN after exactly WARMUP_CYC cycles in WARM.
REQ-019 RUN SHALL generate a sample strobe every SAMPLE_DIV cycles, with the first strobe on the SAMPLE_DIV-th cycle in RUN, capturing ro_s on each strobe.
REQ-020 RUN SHALL group strobes into pairs (first, second) and apply von Neumann debiasing: 01 emits bit 0, 10 emits bit 1, 00 and 11 emit nothing.
REQ-021 Emitted bits SHALL shift in at the LSB, with a left shift, so the first emitted bit ends up in data_out[WORD_W-1].
REQ-022 When the WORD_W-th bit is emitted, the next cycle SHALL present the word on data_out, assert data_valid=1, and enter HOLD.
REQ-023 HOLD SHALL keep data_out and data_valid stable, pause sampling, and keep fro_en=1.
REQ-024 In HOLD, a cycle with data_valid&&data_ready SHALL accept the word: the next cycle data_valid=0, and the bit count, pair phase and divider clear and the FSM returns to RUN.
REQ-025 data_ready while data_valid=0 SHALL have no effect.
REQ-026 en=0 in WARM, RUN or HOLD SHALL return the FSM to IDLE the next cycle, discarding the partial word and pair and deasserting data_valid.
REQ-027 SHALL count consecutive identical raw samples, restarting at 1 on a change and counting across pair boundaries but only in RUN.
REQ-028 When the count reaches REPEAT_LIMIT, alarm SHALL set the next cycle, and the FSM SHALL go to IDLE and discard pending data.
REQ-029 alarm SHALL stay 1 and block exit from IDLE until rst_n asserts.
REQ-030 If alarm trips and the word completes in the same cycle, alarm SHALL take priority and no word is presented.

Reset
REQ-031 While rst_n=0 the block SHALL be in IDLE with fro_en=0, fro_rst=1, data_out=0, data_valid=0, alarm=0, and all counters and synchronizer flops at 0.
REQ-032 Reset assertion SHALL take effect immediately without a clock.
REQ-033 After deassertion, the first state change SHALL occur on the first clk edge with rst_n=1.
REQ-034 Reset mid-word or in HOLD SHALL discard all data.

Verification
REQ-035 Defaults, en=1, ro_in toggled so the pairs are 10,01,10,10,01,01,10,01 -> fro_rst falls one cycle after en, first strobe 16+4 cycles later, data_out=8'b10110010 with data_valid after 64 RUN cycles.
REQ-036 Pairs 00,11 interleaved with the above sequence -> the same word, delivered 16 strobes later.
REQ-037 data_ready=0 for 50 cycles in HOLD -> data_out and data_valid stable for those 50 cycles, no strobes; ready=1 -> valid drops the next cycle and sampling restarts.
REQ-038 ro_in stuck at 1 -> alarm=1 on the cycle after the 32nd strobe, fro_en=0, and en toggling causes no exit from IDLE until rst_n pulses.
REQ-039 en dropped after 5 bits emitted, then reasserted -> the next word contains only post-reassert bits.
REQ-040 rst_n asserted asynchronously mid-HOLD -> data_valid=0 and fro_rst=1 before the next clk edge.
